// File: rtl/lsu_bus_bridge_if.sv
// -----------------------------------------------------------------------------
// lsu_bus_bridge_if
//
// Data-memory bus between the LSU bridge (master) and the memory system (slave).
// The request channel is a valid/ready handshake; the response channel is a
// single-cycle valid pulse per request, returned in order.
//
//   req_valid   master -> slave  request valid, held until req_ready
//   req_ready   slave  -> master request accepted
//   req_we      master -> slave  1 = write, 0 = read
//   req_addr    master -> slave  8-byte-aligned address
//   req_be      master -> slave  byte enables (all ones for reads)
//   req_wdata   master -> slave  write data, lane-replicated
//   resp_valid  slave  -> master response valid, one cycle per request
//   resp_rdata  slave  -> master read data (don't-care for writes)
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 64
`endif

interface lsu_bus_bridge_if;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [`XLEN-1:0] req_addr;
    logic [7:0]       req_be;
    logic [`XLEN-1:0] req_wdata;
    logic             resp_valid;
    logic [`XLEN-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/lsu_bus_bridge.sv
// -----------------------------------------------------------------------------
// lsu_bus_bridge
//
// Turns the mem stage's single-cycle RAM port into one bus transaction per
// access. The pipeline is stalled from the cycle the access is seen until the
// response (or a timeout) arrives; the result is presented for exactly one
// DONE cycle with stall low, during which the mem stage consumes it. The raw
// 64-bit word is returned; lane selection and sign extension stay upstream.
//
// A response that never arrives is abandoned after TIMEOUT_CYC cycles in
// RESP. Because the bus still owes that response, a "stale" flag remembers
// it so the late pulse is swallowed instead of being taken as the answer to
// a later access.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   ram_addr_i      access address, bits [2:0] are zero
//   ram_wen_i       write request (only an access if ram_byte_en_i != 0)
//   ram_byte_en_i   write byte enables
//   ram_wdata_i     write data, lane-replicated
//   ram_ren_i       read request
//   ram_rdata_o     read word, valid in the DONE cycle only (0 for writes)
//   stall_o         hold the pipeline; RAM-port inputs are stable while high
//   err_o           one-cycle pulse in DONE when the access timed out
//   bus             data-memory bus, master side
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 64
`endif

module lsu_bus_bridge #(
    parameter int unsigned TIMEOUT_CYC = 255,  // legal range 1 .. 2**CNT_W-1
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [`XLEN-1:0]  ram_addr_i,
    input  logic              ram_wen_i,
    input  logic [7:0]        ram_byte_en_i,
    input  logic [`XLEN-1:0]  ram_wdata_i,
    input  logic              ram_ren_i,
    output logic [`XLEN-1:0]  ram_rdata_o,
    output logic              stall_o,
    output logic              err_o,
    lsu_bus_bridge_if.master  bus
);

    // Counter value seen in the last RESP cycle before giving up. The counter
    // starts at 0 in the first RESP cycle, so this allows TIMEOUT_CYC cycles.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [`XLEN-1:0] addr_q, addr_d;
    logic [7:0]       be_q, be_d;
    logic [`XLEN-1:0] wdata_q, wdata_d;
    logic [`XLEN-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             stale_q, stale_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic wr_access;
    logic access;
    logic resp_fresh;

    // A write with no enabled byte lane does nothing, so it must not stall.
    // When a real write and a read are requested together the write wins.
    assign wr_access  = ram_wen_i && (ram_byte_en_i != 8'h00);
    assign access     = wr_access || ram_ren_i;

    // A response only belongs to the current access when no abandoned
    // access is still owed one.
    assign resp_fresh = bus.resp_valid && !stale_q;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        stale_d = stale_q;
        cnt_d   = cnt_q;
        stall_o = 1'b0;

        // Any response pulse settles the one owed to an abandoned access.
        // In RESP this is also how a stale pulse gets swallowed; a timeout
        // below may set the flag again in the same cycle.
        if (bus.resp_valid) begin
            stale_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                stall_o = access;
                if (access) begin
                    we_d    = wr_access;
                    addr_d  = ram_addr_i;
                    be_d    = wr_access ? ram_byte_en_i : 8'hFF;
                    wdata_d = ram_wdata_i;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                stall_o = 1'b1;
                if (bus.req_ready) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (resp_fresh) begin
                    rdata_d = we_q ? '0 : bus.resp_rdata;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == LAST_CNT) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    stale_d = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // stall_o stays low: the pipeline advances and takes rdata now.
                err_d   = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 8'h00;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            stale_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, regardless of statement order.
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            stale_q <= stale_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all come straight from registers (valid from the state flop).
    // -------------------------------------------------------------------------
    assign bus.req_valid = (state_q == S_REQ);
    assign bus.req_we    = we_q;
    assign bus.req_addr  = addr_q;
    assign bus.req_be    = be_q;
    assign bus.req_wdata = wdata_q;
    assign ram_rdata_o   = rdata_q;
    assign err_o         = err_q;

    // -------------------------------------------------------------------------
    // Protocol properties
    // -------------------------------------------------------------------------
    a_valid_held : assert property (@(posedge clk) disable iff (rst)
        (bus.req_valid && !bus.req_ready) |=> bus.req_valid);

    a_fields_stable : assert property (@(posedge clk) disable iff (rst)
        (bus.req_valid && !bus.req_ready) |=>
            $stable({bus.req_we, bus.req_addr, bus.req_be, bus.req_wdata}));

    a_err_only_done : assert property (@(posedge clk) disable iff (rst)
        err_q |-> (state_q == S_DONE));

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_lsu_bus_bridge
//
// Drives the RAM port and plays the bus slave. For each access the expected
// per-cycle behaviour is worked out from the transaction rules (one IDLE
// cycle, REQ until ready, RESP until the first response not owed to an
// abandoned access or until the timeout, then one DONE cycle) and queued;
// a single compare process checks the DUT against that queue every cycle.
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 64
`endif

module tb_lsu_bus_bridge;

    localparam int T_CYC = 255;

    typedef struct {
        bit          zero_all;
        bit          stall;
        bit          valid;
        bit          we;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        bit          chk_wdata;
        bit          done;
        logic [63:0] rdata;
        bit          err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [63:0] ram_addr;
    logic        ram_wen;
    logic [7:0]  ram_be;
    logic [63:0] ram_wdata;
    logic        ram_ren;
    logic [63:0] ram_rdata;
    logic        stall;
    logic        err;

    lsu_bus_bridge_if bus_if ();

    lsu_bus_bridge #(
        .TIMEOUT_CYC (T_CYC),
        .CNT_W       (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ram_addr_i    (ram_addr),
        .ram_wen_i     (ram_wen),
        .ram_byte_en_i (ram_be),
        .ram_wdata_i   (ram_wdata),
        .ram_ren_i     (ram_ren),
        .ram_rdata_o   (ram_rdata),
        .stall_o       (stall),
        .err_o         (err),
        .bus           (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];
    bit   m_stale  = 1'b0;   // model: an abandoned access is still owed a response
    bit   noise    = 1'b0;   // randomise req_ready outside REQ

    // Observations collected by the compare process for literal checks.
    int          run_cnt     = 0;
    int          last_run    = 0;
    int          vrun_cnt    = 0;
    int          last_vrun   = 0;
    logic [63:0] done_rdata  = '0;
    logic        done_err    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t blank();
        exp_t e;
        e.zero_all  = 1'b0;
        e.stall     = 1'b0;
        e.valid     = 1'b0;
        e.we        = 1'b0;
        e.addr      = '0;
        e.be        = '0;
        e.wdata     = '0;
        e.chk_wdata = 1'b0;
        e.done      = 1'b0;
        e.rdata     = '0;
        e.err       = 1'b0;
        return e;
    endfunction

    // ---------------------------------------------------------------- compare
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("stall", stall, e.stall);
                check("req_valid", bus_if.req_valid, e.valid);
                check("err", err, e.err);
                if (e.zero_all) begin
                    check("rst_req_we", bus_if.req_we, 0);
                    check("rst_req_addr", bus_if.req_addr, 0);
                    check("rst_req_be", bus_if.req_be, 0);
                    check("rst_req_wdata", bus_if.req_wdata, 0);
                    check("rst_rdata", ram_rdata, 0);
                end
                if (e.valid) begin
                    check("req_we", bus_if.req_we, e.we);
                    check("req_addr", bus_if.req_addr, e.addr);
                    check("req_be", bus_if.req_be, e.be);
                    if (e.chk_wdata) check("req_wdata", bus_if.req_wdata, e.wdata);
                end
                if (e.done) begin
                    check("done_rdata", ram_rdata, e.rdata);
                    done_rdata = ram_rdata;
                    done_err   = err;
                end
            end
            if (stall === 1'b1) run_cnt++;
            else begin
                if (run_cnt != 0) last_run = run_cnt;
                run_cnt = 0;
            end
            if (bus_if.req_valid === 1'b1) vrun_cnt++;
            else begin
                if (vrun_cnt != 0) last_vrun = vrun_cnt;
                vrun_cnt = 0;
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic step();
        @(posedge clk);
        #1;
        bus_if.resp_valid = 1'b0;
        bus_if.resp_rdata = {$urandom, $urandom};
        bus_if.req_ready  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    // n cycles without an access; optional response pulse at cycle pulse_at;
    // wen_noise raises ram_wen with zero byte enables (not an access).
    task automatic idle_cycles(input int n, input int pulse_at, input bit wen_noise);
        for (int i = 1; i <= n; i++) begin
            step();
            ram_wen = wen_noise;
            ram_ren = 1'b0;
            ram_be  = 8'h00;
            if (i == pulse_at) begin
                bus_if.resp_valid = 1'b1;
                m_stale = 1'b0;
            end
            exp_q.push_back(blank());
        end
    endtask

    // One access. d: cycles ready stays low in REQ. r: RESP cycle carrying the
    // real response (0 = never). s: RESP cycle carrying an orphan response
    // (0 = none). Responses are numbered from 1 = first RESP cycle.
    task automatic run_access(input bit we_i, input bit ren_i, input logic [63:0] addr,
                              input logic [7:0] be, input logic [63:0] wd,
                              input int d, input int r, input int s, input logic [63:0] rd);
        exp_t e;
        bit   is_wr;
        bit   fin;
        bit   timed_out;
        bit   pulse;
        int   j;
        is_wr     = we_i && (be != 8'h00);
        fin       = 1'b0;
        timed_out = 1'b0;
        // IDLE: access seen, stall combinationally
        step();
        ram_wen = we_i; ram_ren = ren_i; ram_addr = addr; ram_be = be; ram_wdata = wd;
        e = blank(); e.stall = 1'b1;
        exp_q.push_back(e);
        // REQ
        for (int k = 0; k <= d; k++) begin
            step();
            bus_if.req_ready = (k == d);
            e = blank();
            e.stall = 1'b1; e.valid = 1'b1; e.we = is_wr; e.addr = addr;
            e.be = is_wr ? be : 8'hFF; e.wdata = wd; e.chk_wdata = is_wr;
            exp_q.push_back(e);
        end
        // RESP
        j = 0;
        while (!fin) begin
            j++;
            step();
            pulse = ((r != 0) && (j == r)) || ((s != 0) && (j == s));
            bus_if.resp_valid = pulse;
            if ((r != 0) && (j == r)) bus_if.resp_rdata = rd;
            e = blank(); e.stall = 1'b1;
            exp_q.push_back(e);
            if (pulse && !m_stale) fin = 1'b1;
            else begin
                if (pulse) m_stale = 1'b0;
                if (j == T_CYC) begin
                    fin = 1'b1; timed_out = 1'b1; m_stale = 1'b1;
                end
            end
        end
        // DONE
        step();
        e = blank(); e.done = 1'b1; e.err = timed_out;
        e.rdata = (timed_out || is_wr) ? 64'h0 : rd;
        exp_q.push_back(e);
    endtask

    task automatic reset_mid_resp();
        exp_t e;
        step();
        ram_wen = 1'b0; ram_ren = 1'b1; ram_addr = 64'h3000; ram_be = 8'h00;
        e = blank(); e.stall = 1'b1; exp_q.push_back(e);
        step();
        bus_if.req_ready = 1'b1;
        e = blank(); e.stall = 1'b1; e.valid = 1'b1; e.addr = 64'h3000; e.be = 8'hFF;
        exp_q.push_back(e);
        for (int i = 0; i < 3; i++) begin
            step();
            e = blank(); e.stall = 1'b1; exp_q.push_back(e);
        end
        step();
        rst = 1'b1; ram_ren = 1'b0; ram_wen = 1'b0;
        m_stale = 1'b0;
        e = blank(); e.zero_all = 1'b1; exp_q.push_back(e);
        step();
        rst = 1'b0;
        bus_if.resp_valid = 1'b1;   // response to the killed access: ignored
        exp_q.push_back(blank());
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        exp_t e;
        rst = 1'b1;
        ram_addr = '0; ram_wen = 1'b0; ram_be = '0; ram_wdata = '0; ram_ren = 1'b0;
        bus_if.req_ready = 1'b0; bus_if.resp_valid = 1'b0; bus_if.resp_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            e = blank(); e.zero_all = 1'b1; exp_q.push_back(e);
        end
        step();
        rst = 1'b0;
        exp_q.push_back(blank());

        // Minimum-latency read
        run_access(1'b0, 1'b1, 64'h1000, 8'h00, 64'h0, 0, 1, 0, 64'h1122334455667788);
        idle_cycles(1, 0, 1'b0);
        check("t1_stall_cycles", last_run, 3);
        check("t1_rdata", done_rdata, 64'h1122334455667788);
        check("t1_err", done_err, 0);

        // Write with ready held low for 4 cycles
        run_access(1'b1, 1'b0, 64'h2008, 8'h0C, 64'hAABBAABBAABBAABB, 4, 2, 0, 64'hDEAD);
        idle_cycles(1, 0, 1'b0);
        check("t2_valid_cycles", last_vrun, 5);
        check("t2_rdata", done_rdata, 0);

        // Timeout, late response 10 cycles later, then a clean read
        run_access(1'b0, 1'b1, 64'h4000, 8'h00, 64'h0, 0, 0, 0, 64'h0);
        idle_cycles(1, 0, 1'b0);
        check("t3_err", done_err, 1);
        check("t3_stall_cycles", last_run, 257);
        idle_cycles(9, 9, 1'b0);
        run_access(1'b0, 1'b1, 64'h4008, 8'h00, 64'h0, 1, 3, 0, 64'hCAFEF00D12345678);
        idle_cycles(1, 0, 1'b0);
        check("t3_next_rdata", done_rdata, 64'hCAFEF00D12345678);
        check("t3_next_err", done_err, 0);

        // Write with no byte enables: never an access
        idle_cycles(4, 0, 1'b1);

        // wen and ren together, then a back-to-back read
        run_access(1'b1, 1'b1, 64'h5000, 8'hF0, 64'h0102030405060708, 0, 1, 0, 64'h0);
        run_access(1'b0, 1'b1, 64'h5008, 8'h00, 64'h0, 0, 1, 0, 64'h8877665544332211);
        idle_cycles(1, 0, 1'b0);
        check("t5_b2b_rdata", done_rdata, 64'h8877665544332211);

        // Reset in RESP, then a clean read
        reset_mid_resp();
        run_access(1'b0, 1'b1, 64'h6000, 8'h00, 64'h0, 0, 1, 0, 64'h0F0F0F0F0F0F0F0F);
        idle_cycles(1, 0, 1'b0);
        check("t6_rdata", done_rdata, 64'h0F0F0F0F0F0F0F0F);

        // Response in the very last allowed RESP cycle still completes
        run_access(1'b0, 1'b1, 64'h7000, 8'h00, 64'h0, 0, T_CYC, 0, 64'h5A5A5A5A5A5A5A5A);
        idle_cycles(1, 0, 1'b0);
        check("t7_err", done_err, 0);
        check("t7_rdata", done_rdata, 64'h5A5A5A5A5A5A5A5A);
        check("t7_stall_cycles", last_run, 257);

        // Timeout, then the orphan response lands inside the next RESP
        run_access(1'b0, 1'b1, 64'h8000, 8'h00, 64'h0, 0, 0, 0, 64'h0);
        run_access(1'b0, 1'b1, 64'h8008, 8'h00, 64'h0, 0, 4, 2, 64'h1234567890ABCDEF);
        idle_cycles(1, 0, 1'b0);
        check("t8_rdata", done_rdata, 64'h1234567890ABCDEF);
        check("t8_err", done_err, 0);

        // Randomised traffic
        noise = 1'b1;
        for (int n = 0; n < 200; n++) begin
            int          kind;
            int          d;
            int          r;
            int          s;
            int          gap;
            bit          w;
            bit          rd_en;
            logic [7:0]  be;
            logic [63:0] addr;
            kind  = $urandom_range(0, 9);
            w     = (kind >= 4);
            rd_en = (kind < 4) || (kind == 8);
            be    = w ? 8'($urandom_range(1, 255)) : 8'($urandom_range(0, 255));
            addr  = {$urandom, $urandom} & ~64'h7;
            d     = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 3);
            r     = ($urandom_range(0, 29) == 0) ? 0 : $urandom_range(1, 6);
            s     = 0;
            gap   = $urandom_range(0, 2);
            if (kind == 9) begin
                idle_cycles(gap + 1, 0, 1'b1);
            end else begin
                if (m_stale) begin
                    if ($urandom_range(0, 1) == 1) begin
                        s = $urandom_range(1, 3);
                        r = s + $urandom_range(1, 4);
                    end else begin
                        idle_cycles(gap + 1, 1, 1'b0);
                    end
                end
                run_access(w, rd_en, addr, be, {$urandom, $urandom}, d, r, s, {$urandom, $urandom});
                if (gap != 0) idle_cycles(gap, 0, 1'($urandom_range(0, 1)));
            end
        end
        idle_cycles(2, 0, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
Sits directly downstream of the load/store (mem) stage. Converts its single-cycle RAM port (8-byte-aligned address, byte enables, read/write enables) into a valid/ready request and valid response on the data memory bus. Holds the pipeline with a stall while an access is in flight and returns the raw 64-bit read word to the mem stage. The mem stage does its own byte-lane selection and sign extension. The block has a response timeout and discards late responses.

Parameters:
TIMEOUT_CYC, 255, response-wait cycles before an access is aborted; legal range 1..2^CNT_W-1
CNT_W, 8, width of the timeout counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
ram_addr_i  in  `XLEN  access address; bits [2:0] are always 0
ram_wen_i  in  1  write request
ram_byte_en_i  in  8  write byte enables
ram_wdata_i  in  `XLEN  write data, already lane-replicated
ram_ren_i  in  1  read request
ram_rdata_o  out  `XLEN  read word; valid only in the DONE cycle
stall_o  out  1  holds the pipeline; mem-stage inputs stay stable while it is 1
err_o  out  1  one-cycle pulse in DONE when the access timed out
bus_req_valid_o  out  1  request valid
bus_req_ready_i  in  1  request accepted
bus_req_we_o  out  1  1 = write, 0 = read
bus_req_addr_o  out  `XLEN  registered address
bus_req_be_o  out  8  byte enables; 8'hFF for reads
bus_req_wdata_o  out  `XLEN  registered write data
bus_resp_valid_i  in  1  response valid, one cycle per request, in order
bus_resp_rdata_i  in  `XLEN  read data; ignored for writes

Behaviour:
- Reset, asynchronous: state=IDLE, stale=0, counter=0. All registered outputs are 0: bus_req_*, ram_rdata_o, err_o.
- States: IDLE, REQ, RESP, DONE.
- An access is detected in IDLE when (ram_wen_i & ram_byte_en_i!=0) or ram_ren_i is high.
  - If both wen and ren are high, the write wins.
  - A write with byte_en==0 is not an access: no stall, no bus traffic.
- IDLE:
  - stall_o = access detected (combinational).
  - On an access: register addr, we, be, wdata, then go to REQ.
- REQ:
  - bus_req_valid_o=1 and stall_o=1.
  - Request fields stay stable until bus_req_ready_i=1.
  - On handshake: go to RESP and clear the counter.
  - Valid must not drop before ready.
- RESP:
  - stall_o=1; the counter increments every cycle.
  - On bus_resp_valid_i with stale=0: capture rdata (reads) or 0 (writes) into ram_rdata_o, then go to DONE.
  - On bus_resp_valid_i with stale=1: clear stale, stay in RESP, keep counting.
  - Timeout when counter==TIMEOUT_CYC-1 and no valid, non-stale response that cycle: ram_rdata_o=0, err_o=1, stale=1, go to DONE.
- DONE:
  - stall_o=0, so the pipeline advances this cycle and consumes ram_rdata_o.
  - Next state is unconditionally IDLE; err_o clears on leaving DONE.
- bus_resp_valid_i is ignored in IDLE, REQ and DONE, except that it clears stale.
- Minimum access latency, with ready in REQ and response in the first RESP cycle: 3 stall cycles, then one DONE cycle.
- Back-to-back accesses: the DONE cycle is followed by IDLE, which samples the next instruction's request.
- Reset mid-access: the FSM returns to IDLE immediately and no completion is signalled.

Test Plan:
- Read 0x1000, ready=1 at the first REQ cycle, response 0x1122334455667788 one cycle later -> stall_o high 3 cycles, then DONE with ram_rdata_o=0x1122334455667788, err_o=0; bus_req_be_o=8'hFF, bus_req_we_o=0.
- Write 0x2008, be=8'h0C, wdata=0xAABBAABBAABBAABB, ready held low 4 cycles -> valid held with stable addr/be/wdata for 5 cycles; after the response, ram_rdata_o=0 in DONE.
- No response for 255 RESP cycles -> DONE with err_o=1, ram_rdata_o=0. A late response 10 cycles later is dropped; the next read completes with its own data.
- ram_wen_i=1 with byte_en=0 -> stall_o=0, bus_req_valid_o never asserts.
- wen and ren both high -> bus_req_we_o=1. A read immediately after DONE starts a new REQ in the following cycle.
- Assert rst while in RESP -> next edge all outputs 0, state IDLE; a response arriving after reset is ignored.
